if_neuron_layer: RTL and testbench
==================================

# if_neuron_layer

Integrate-and-fire neuron layer that sits directly upstream of the layer controller. Each step it sums the weights of the active input spikes per neuron, and accumulates the sum into a saturating membrane potential. A neuron fires a one-cycle spike when its potential reaches threshold, then enters a refractory period. The layer controller consumes `spike_out` and returns `neuron_rst`, which this block obeys.

## Interface
- `NUM_INPUTS`, 4: number of input spike lines.
- `NUM_NEURONS`, 1: number of neurons in the layer.
- `WEIGHT_WIDTH`, 8: unsigned weight width.
- `POT_WIDTH`, 16: membrane potential width.
- `THRESHOLD`, 1000: firing threshold. Must be ≥1 and ≤ 2^POT_WIDTH−1.
- `REFRAC`, 5: refractory length in steps. 0 means no refractory period.
- `LEAK`, 1: per-step leak amount. Used only with `IF_LEAK_EN`.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `step_en`  in  1  one-cycle strobe; advances all neurons by one timestep.
- `spike_in`  in  NUM_INPUTS  input spikes; sampled only when `step_en`=1.
- `weights`  in  NUM_NEURONS*NUM_INPUTS*WEIGHT_WIDTH  flat weight vector. Weight (n,i) is at bits [(n*NUM_INPUTS+i)*WEIGHT_WIDTH +: WEIGHT_WIDTH].
- `neuron_rst`  in  NUM_NEURONS  per-neuron reset from the layer controller; active high, synchronous.
- `spike_out`  out  NUM_NEURONS  registered spike pulse per neuron.
- `refrac_busy`  out  NUM_NEURONS  1 while the neuron's refractory count ≠ 0.

## Operation
- Per-neuron state:
  - `pot` [POT_WIDTH-1:0]
  - `rcnt` [clog2(REFRAC+1)-1:0]
- Weighted sum: sum_n = Σ over i where spike_in[i]=1 of w(n,i).
  - Width is WEIGHT_WIDTH+clog2(NUM_INPUTS+1); it never overflows.
- Per-neuron step logic, evaluated in this priority order:
  1. If `neuron_rst[n]`=1: `pot`←0, `rcnt`←REFRAC, `spike_out[n]`←0. This holds for every cycle it is asserted, regardless of `step_en`.
  2. Else if `step_en`=1 and `rcnt`≠0: `rcnt`←rcnt−1. `pot` is held and inputs are ignored. `spike_out[n]`←0.
  3. Else if `step_en`=1:
     - Compute acc = pot + sum_n, saturated at 2^POT_WIDTH−1.
     - If acc ≥ THRESHOLD: `spike_out[n]`←1, `pot`←0, `rcnt`←REFRAC.
     - Otherwise: `pot`←acc, `spike_out[n]`←0.
  4. Else (no `step_en`): `spike_out[n]`←0; all other state is held.
- The layer resets a neuron locally when it fires. The controller's `neuron_rst` pulse arrives one cycle later and reloads `rcnt` to REFRAC again. Net effect: refractory ends REFRAC steps after the last cycle `neuron_rst` is high.
- Neurons are fully independent; there is no lateral inhibition.

## Timing
- Reset values while `rst`=0: `pot`=0, `rcnt`=0, `spike_out`=0, `refrac_busy`=0.
- Latency: `step_en` at cycle t → `spike_out` valid at cycle t+1, high for exactly one cycle.
- Back-to-back `step_en` is allowed every cycle. The minimum step spacing is 1 clock.
- `refrac_busy` is registered and reflects `rcnt` after the edge.
- `step_en` and `neuron_rst[n]` in the same cycle: `neuron_rst` wins and that step is lost for neuron n.
- Saturation:
  - acc is clamped at all-ones before the threshold compare.
  - If THRESHOLD = 2^POT_WIDTH−1, a saturated neuron fires.
- REFRAC=0: a neuron may fire on consecutive steps, subject only to `neuron_rst`.
- Deasserting `rst` mid-step: no spike is produced for any `step_en` sampled while `rst`=0.

## Configuration
- `IF_LEAK_EN` defined:
  - In step case 3, the potential leaks before integration: acc = sat(max(pot−LEAK,0) + sum_n).
  - Leak is not applied during refractory steps or on cycles without `step_en`.
- `IF_LEAK_EN` undefined: pure integrate-and-fire. The `LEAK` parameter is ignored and no leak logic is synthesised.

## Test plan
Unless noted, all scenarios use NUM_INPUTS=4, NUM_NEURONS=2, WEIGHT_WIDTH=8, POT_WIDTH=12, THRESHOLD=100, REFRAC=3, without leak.

- **Accumulate to fire:** w(0,*)=30, spike_in=4'b0001, 4 consecutive steps → pot goes 30, 60, 90. `spike_out[0]` pulses 1 cycle after the 4th step (acc=120), then pot=0 and `refrac_busy[0]`=1.
- **Refractory:** after the fire above, apply 3 steps with spike_in=4'b1111 → pot stays 0 and no spike. The 5th step after the fire integrates 120 and fires again.
- **Controller reset priority:** hold `neuron_rst[1]`=1 for 2 cycles with `step_en`=1 and w(1,*)=200 → no spike, pot=0, rcnt=3 when `neuron_rst` drops.
- **Saturation:** POT_WIDTH=8, THRESHOLD=255, w=255, spike_in=4'b1111 → acc clamps to 255 and the neuron fires in 1 step.
- **Async reset mid-run:** drop `rst` low between clock edges with pot=90 → all outputs 0 immediately. After release, one step of 30 gives pot=30 and no spike.
- **Leak (`IF_LEAK_EN`, LEAK=10):** w=30, input active on step 1 only, then 3 idle steps → pot goes 30, 20, 10, 0 and stays at 0.

Source files
------------

// File: rtl/if_neuron_layer.sv
// Integrate-and-fire neuron layer: weighted spike sum, saturating membrane potential, refractory count.
// Latency 1 cycle step_en->spike_out; no backpressure, a step is accepted every cycle. Optional leak: IF_LEAK_EN.
module if_neuron_layer #(
  parameter int NUM_INPUTS   = 4,
  parameter int NUM_NEURONS  = 1,
  parameter int WEIGHT_WIDTH = 8,
  parameter int POT_WIDTH    = 16,
  parameter int THRESHOLD    = 1000,
  parameter int REFRAC       = 5,
  parameter int LEAK         = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        step_en,
  input  logic [NUM_INPUTS-1:0]                       spike_in,
  input  logic [NUM_NEURONS*NUM_INPUTS*WEIGHT_WIDTH-1:0] weights,
  input  logic [NUM_NEURONS-1:0]                      neuron_rst,
  output logic [NUM_NEURONS-1:0]                      spike_out,
  output logic [NUM_NEURONS-1:0]                      refrac_busy
);

  localparam int SUM_W = WEIGHT_WIDTH + $clog2(NUM_INPUTS + 1);
  // A REFRAC of 0 would give a zero-width counter, so keep at least one bit.
  localparam int RW    = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam int EXT_W = ((POT_WIDTH > SUM_W) ? POT_WIDTH : SUM_W) + 1;

  localparam logic [POT_WIDTH-1:0] POT_MAX = '1;
  localparam logic [POT_WIDTH-1:0] THR     = POT_WIDTH'(THRESHOLD);
  localparam logic [RW-1:0]        RLOAD   = RW'(REFRAC);

  logic [POT_WIDTH-1:0] pot_q  [NUM_NEURONS];
  logic [POT_WIDTH-1:0] pot_d  [NUM_NEURONS];
  logic [RW-1:0]        rcnt_q [NUM_NEURONS];
  logic [RW-1:0]        rcnt_d [NUM_NEURONS];
  logic [SUM_W-1:0]     sum    [NUM_NEURONS];
  logic [POT_WIDTH-1:0] base   [NUM_NEURONS];
  logic [EXT_W-1:0]     ext    [NUM_NEURONS];
  logic [POT_WIDTH-1:0] acc    [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] spk_d;
  logic [NUM_NEURONS-1:0] spk_q;
  logic [NUM_NEURONS-1:0] busy_q;

  always_comb begin
    spk_d = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      sum[n] = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (spike_in[i])
          sum[n] = sum[n] + SUM_W'(weights[(n*NUM_INPUTS+i)*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
      end
`ifdef IF_LEAK_EN
      base[n] = (pot_q[n] > POT_WIDTH'(LEAK)) ? pot_q[n] - POT_WIDTH'(LEAK) : '0;
`else
      base[n] = pot_q[n];
`endif
      // Clamp before the threshold compare so a saturated neuron can still fire at THRESHOLD=max.
      ext[n] = EXT_W'(base[n]) + EXT_W'(sum[n]);
      acc[n] = (ext[n] > EXT_W'(POT_MAX)) ? POT_MAX : ext[n][POT_WIDTH-1:0];

      pot_d[n]  = pot_q[n];
      rcnt_d[n] = rcnt_q[n];
      if (neuron_rst[n]) begin
        pot_d[n]  = '0;
        rcnt_d[n] = RLOAD;
      end else if (step_en) begin
        if (rcnt_q[n] != '0) begin
          rcnt_d[n] = rcnt_q[n] - 1'b1;
        end else if (acc[n] >= THR) begin
          spk_d[n]  = 1'b1;
          pot_d[n]  = '0;
          rcnt_d[n] = RLOAD;
        end else begin
          pot_d[n] = acc[n];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spk_q  <= '0;
      busy_q <= '0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        pot_q[n]  <= '0;
        rcnt_q[n] <= '0;
      end
    end else begin
      spk_q <= spk_d;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        pot_q[n]  <= pot_d[n];
        rcnt_q[n] <= rcnt_d[n];
        busy_q[n] <= (rcnt_d[n] != '0);
      end
    end
  end

  assign spike_out   = spk_q;
  assign refrac_busy = busy_q;

endmodule

// File: tb/tb_if_neuron_layer.sv
// Directed bench for if_neuron_layer: accumulate/fire, refractory, controller reset, saturation, async reset.
module tb_if_neuron_layer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step_en = 1'b0;
  logic [3:0]  spike_in = '0;
  logic [63:0] weights = '0;
  logic [1:0]  neuron_rst = '0;
  logic [1:0]  spike_out;
  logic [1:0]  refrac_busy;

  logic        sat_step = 1'b0;
  logic [0:0]  sat_spk;
  logic [0:0]  sat_busy;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  if_neuron_layer #(
    .NUM_INPUTS(4), .NUM_NEURONS(2), .WEIGHT_WIDTH(8), .POT_WIDTH(12),
    .THRESHOLD(100), .REFRAC(3), .LEAK(10)
  ) dut (
    .clk(clk), .rst(rst), .step_en(step_en), .spike_in(spike_in), .weights(weights),
    .neuron_rst(neuron_rst), .spike_out(spike_out), .refrac_busy(refrac_busy)
  );

  if_neuron_layer #(
    .NUM_INPUTS(4), .NUM_NEURONS(1), .WEIGHT_WIDTH(8), .POT_WIDTH(8),
    .THRESHOLD(255), .REFRAC(3), .LEAK(10)
  ) u_sat (
    .clk(clk), .rst(rst), .step_en(sat_step), .spike_in(spike_in), .weights(32'hFFFF_FFFF),
    .neuron_rst(1'b0), .spike_out(sat_spk), .refrac_busy(sat_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_w(input int n, input logic [7:0] v);
    for (int i = 0; i < 4; i++) weights[(n*4+i)*8 +: 8] = v;
  endtask

  // One clock: drive at negedge, sample 1 time unit after the rising edge.
  task automatic cyc(input logic st, input logic [3:0] sp, input logic [1:0] nr);
    @(negedge clk);
    step_en = st;
    spike_in = sp;
    neuron_rst = nr;
    @(posedge clk);
    #1;
    step_en = 1'b0;
    neuron_rst = '0;
  endtask

  initial begin
    #12;
    check_eq("rst_spike", spike_out, 0);
    check_eq("rst_busy", refrac_busy, 0);
    check_eq("rst_pot0", dut.pot_q[0], 0);
    check_eq("rst_sat_spike", sat_spk, 0);
    @(negedge clk);
    rst = 1'b1;

    // Accumulate to fire: 30, 60, 90, then 120 fires.
    set_w(0, 8'd30);
    set_w(1, 8'd0);
    cyc(1, 4'b0001, 2'b00);
    check_eq("acc_pot_1", dut.pot_q[0], 30);
    cyc(1, 4'b0001, 2'b00);
    check_eq("acc_pot_2", dut.pot_q[0], 60);
    cyc(1, 4'b0001, 2'b00);
    check_eq("acc_pot_3", dut.pot_q[0], 90);
    check_eq("acc_nospike_3", spike_out, 0);
    cyc(1, 4'b0001, 2'b00);
    check_eq("fire_spike", spike_out, 2'b01);
    check_eq("fire_pot", dut.pot_q[0], 0);
    check_eq("fire_busy", refrac_busy, 2'b01);

    // Refractory: controller pulse collides with step 1, steps 2-4 are refractory, step 5 fires.
    cyc(1, 4'b1111, 2'b01);
    check_eq("refr_pulse_end", spike_out, 0);
    check_eq("refr_rcnt_reload", dut.rcnt_q[0], 3);
    for (int k = 2; k <= 4; k++) begin
      cyc(1, 4'b1111, 2'b00);
      check_eq("refr_nospike", spike_out, 0);
      check_eq("refr_pot_hold", dut.pot_q[0], 0);
    end
    check_eq("refr_busy_clear", refrac_busy, 0);
    cyc(1, 4'b1111, 2'b00);
    check_eq("refr_refire", spike_out, 2'b01);

    // Controller reset wins over step_en on neuron 1.
    set_w(1, 8'd200);
    cyc(1, 4'b1111, 2'b10);
    check_eq("nrst_nospike_1", spike_out, 0);
    cyc(1, 4'b1111, 2'b10);
    check_eq("nrst_nospike_2", spike_out, 0);
    check_eq("nrst_pot1", dut.pot_q[1], 0);
    check_eq("nrst_busy", refrac_busy, 2'b11);
    cyc(0, 4'b0000, 2'b00);
    check_eq("nrst_rcnt1", dut.rcnt_q[1], 3);

    // Async reset mid-run with pot0 = 90 and neuron 1 refractory.
    rst = 1'b0;
    cyc(0, 4'b0000, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    set_w(0, 8'd30);
    set_w(1, 8'd0);
    cyc(1, 4'b0001, 2'b00);
    cyc(1, 4'b0001, 2'b00);
    cyc(1, 4'b0001, 2'b10);
    check_eq("pre_arst_pot0", dut.pot_q[0], 90);
    check_eq("pre_arst_busy", refrac_busy, 2'b10);
    #3;
    rst = 1'b0;
    #1;
    check_eq("arst_pot0", dut.pot_q[0], 0);
    check_eq("arst_busy", refrac_busy, 0);
    check_eq("arst_spike", spike_out, 0);
    check_eq("arst_rcnt1", dut.rcnt_q[1], 0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1, 4'b0001, 2'b00);
    check_eq("post_arst_pot0", dut.pot_q[0], 30);
    check_eq("post_arst_nospike", spike_out, 0);

    // Exact threshold: 30 + 70 = 100 fires.
    set_w(0, 8'd70);
    cyc(1, 4'b0001, 2'b00);
    check_eq("thr_exact_spike", spike_out, 2'b01);

    // Saturation: 4*255 clamps to 255 and fires at THRESHOLD = 255.
    @(negedge clk);
    sat_step = 1'b1;
    spike_in = 4'b1111;
    @(posedge clk);
    #1;
    sat_step = 1'b0;
    check_eq("sat_spike", sat_spk, 1);
    check_eq("sat_pot", u_sat.pot_q[0], 0);
    check_eq("sat_busy", sat_busy, 1);
    cyc(0, 4'b0000, 2'b00);
    check_eq("sat_pulse_end", sat_spk, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
